store_write_buffer: RTL and testbench

//  Sits directly downstream of the store queue retire port. It accepts the head store that the SQ presents
//  (wrdata/wraddress/wrmemsize) and acknowledges it with a same-cycle storecomplete, so the SQ frees its head.

---
 rtl/store_write_buffer.sv | 153 +++++++++++++++
 tb/tb_store_write_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Post-commit store write buffer: accepts retiring stores from the SQ head, drains them
// one at a time to the 64-bit memory bus, and offers word forwarding to probing loads.
module store_write_buffer #(
   parameter int WB_DEPTH = 4,
   parameter int XLEN     = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        retireen,
   input  logic                        storeing,
   input  logic [XLEN-1:0]             wrdata,
   input  logic [XLEN-1:0]             wraddress,
   input  logic [2:0]                  wrmemsize,
   output logic                        storecomplete,
   input  logic                        ld_lookup_en,
   input  logic [XLEN-1:0]             ld_addr,
   output logic                        wb_fwd_hit,
   output logic [XLEN-1:0]             wb_fwd_data,
   output logic                        wb_fwd_conflict,
   output logic [1:0]                  proc2mem_command,
   output logic [XLEN-1:0]             proc2mem_addr,
   output logic [63:0]                 proc2mem_data,
   output logic [7:0]                  proc2mem_bmask,
   input  logic                        mem_accept,
   input  logic                        mem_done,
   output logic [$clog2(WB_DEPTH):0]   wb_count,
   output logic                        wb_empty
);
   localparam int PW = $clog2(WB_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t          r_state, w_state_next;
   logic [XLEN-1:0] r_addr [WB_DEPTH];
   logic [XLEN-1:0] r_data [WB_DEPTH];
   logic [1:0]      r_size [WB_DEPTH];
   logic [PW-1:0]   r_head, r_tail;
   logic [CW-1:0]   r_count, w_count_next;
   logic            w_push, w_pop;
   logic            w_unused;

   // Size bit 2 carries no meaning for this buffer.
   assign w_unused = wrmemsize[2];

   // Acceptance looks only at the registered count, so a full buffer never bypasses a pop.
   assign w_push       = (retireen | storeing) && (r_count < CW'(WB_DEPTH));
   assign w_pop        = (r_state == S_WAIT) && mem_done;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   assign storecomplete = w_push;
   assign wb_count      = r_count;
   assign wb_empty      = (r_count == '0);

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_addr[r_tail] <= wraddress;
         r_data[r_tail] <= wrdata;
         r_size[r_tail] <= wrmemsize[1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (r_count != '0) w_state_next = S_REQ;
         S_REQ:  if (mem_accept)    w_state_next = S_WAIT;
         S_WAIT: if (mem_done)      w_state_next = (w_count_next != '0) ? S_REQ : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Head entry formatted into its byte lane of the 64-bit bus word.
   logic [XLEN-1:0] w_head_addr, w_head_masked;
   logic [2:0]      w_head_off;
   logic [7:0]      w_head_base;

   assign w_head_addr = r_addr[r_head];
   assign w_head_off  = w_head_addr[2:0];

   always_comb begin
      w_head_masked = r_data[r_head];
      w_head_base   = 8'h0F;
      case (r_size[r_head])
         2'd0: begin
            w_head_masked = {{(XLEN-8){1'b0}}, r_data[r_head][7:0]};
            w_head_base   = 8'h01;
         end
         2'd1: begin
            w_head_masked = {{(XLEN-16){1'b0}}, r_data[r_head][15:0]};
            w_head_base   = 8'h03;
         end
         default: ;
      endcase
   end

   always_comb begin
      proc2mem_command = 2'b00;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_bmask   = '0;
      if (r_state == S_REQ) begin
         proc2mem_command = 2'b10;
         proc2mem_addr    = {w_head_addr[XLEN-1:3], 3'b000};
         proc2mem_data    = 64'(w_head_masked) << {w_head_off, 3'b000};
         proc2mem_bmask   = w_head_base << w_head_off;
      end
   end

   // Per age position (0 = oldest): physical slot and word-address match.
   logic [PW-1:0] w_slot  [WB_DEPTH];
   logic          w_match [WB_DEPTH];
   logic          w_exact [WB_DEPTH];

   generate
      for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_probe
         assign w_slot[gi]  = r_head + PW'(gi);
         assign w_match[gi] = (CW'(gi) < r_count) &&
                              (r_addr[w_slot[gi]][XLEN-1:2] == ld_addr[XLEN-1:2]);
         assign w_exact[gi] = r_size[w_slot[gi]][1] && (r_addr[w_slot[gi]] == ld_addr);
      end
   endgenerate

   // Scanning oldest to youngest lets the youngest overlapping entry have the last word.
   always_comb begin
      wb_fwd_hit      = 1'b0;
      wb_fwd_conflict = 1'b0;
      wb_fwd_data     = '0;
      if (ld_lookup_en) begin
         for (int i = 0; i < WB_DEPTH; i++) begin
            if (w_match[i]) begin
               wb_fwd_hit      = w_exact[i];
               wb_fwd_conflict = !w_exact[i];
               wb_fwd_data     = w_exact[i] ? r_data[w_slot[i]] : '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized scoreboard bench for store_write_buffer: a queue model predicts acceptance,
// occupancy, forwarding and bus writes; a monitor compares them as the DUT presents them.
module tb_store_write_buffer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        retireen = 1'b0, storeing = 1'b0;
   logic [31:0] wrdata = '0, wraddress = '0;
   logic [2:0]  wrmemsize = '0;
   logic        storecomplete;
   logic        ld_lookup_en = 1'b0;
   logic [31:0] ld_addr = '0;
   logic        wb_fwd_hit, wb_fwd_conflict;
   logic [31:0] wb_fwd_data;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [7:0]  proc2mem_bmask;
   logic        mem_accept = 1'b0, mem_done = 1'b0;
   logic [2:0]  wb_count;
   logic        wb_empty;

   always #5 clock = ~clock;

   store_write_buffer #(.WB_DEPTH(4), .XLEN(32)) dut (
      .clock(clock), .reset(reset), .retireen(retireen), .storeing(storeing),
      .wrdata(wrdata), .wraddress(wraddress), .wrmemsize(wrmemsize),
      .storecomplete(storecomplete), .ld_lookup_en(ld_lookup_en), .ld_addr(ld_addr),
      .wb_fwd_hit(wb_fwd_hit), .wb_fwd_data(wb_fwd_data), .wb_fwd_conflict(wb_fwd_conflict),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .proc2mem_bmask(proc2mem_bmask),
      .mem_accept(mem_accept), .mem_done(mem_done), .wb_count(wb_count), .wb_empty(wb_empty)
   );

   typedef struct {logic [31:0] a; logic [31:0] d; int sz;} ent_t;
   typedef struct {logic [31:0] addr; logic [63:0] data; logic [7:0] mask;} bus_t;
   typedef struct {bit chk_sc; bit sc; int cnt; bit pend; bit chk_ld; bit hit; bit conf; logic [31:0] fd;} cyc_t;

   ent_t mq[$];        // committed, undrained stores, oldest first
   bus_t drain_q[$];   // bus writes still expected, in order
   cyc_t cyc_q[$];     // per-cycle expectations
   bit   pending = 0;  // memory has accepted the head write and owes a done
   int   errors = 0, checks = 0;
   cyc_t mc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bus_t fmt(input ent_t e);
      bus_t b;
      int   off, n;
      off    = int'(e.a[2:0]);
      n      = 1 << e.sz;
      b.addr = {e.a[31:3], 3'b000};
      b.data = '0;
      b.mask = '0;
      for (int k = 0; k < n; k++) begin
         b.data[8*(off+k) +: 8] = e.d[8*k +: 8];
         b.mask[off+k]          = 1'b1;
      end
      return b;
   endfunction

   // One cycle of stimulus; inputs change just after the rising edge.
   task automatic step(input bit do_st, input int acc_pct, input int done_pct, input bit do_ld);
      cyc_t c;
      ent_t e;
      int   n;
      @(posedge clock); #1;
      retireen = 0; storeing = 0; mem_accept = 0; mem_done = 0; ld_lookup_en = 0;
      c = '{default: 0};
      c.cnt  = mq.size();
      c.pend = pending;
      e = '{default: 0};
      if (do_st) begin
         e.sz = int'($urandom_range(0, 2));
         n    = 1 << e.sz;
         e.a  = 32'h200 + (32'($urandom_range(0, 31)) & ~32'(n - 1));
         e.d  = $urandom;
         wraddress = e.a;
         wrdata    = e.d;
         wrmemsize = {1'($urandom_range(0, 1)), 2'(e.sz)};
         if ($urandom_range(0, 1) == 1) retireen = 1; else storeing = 1;
         c.chk_sc = 1;
         c.sc     = (mq.size() < 4);
      end
      if (do_ld) begin
         ld_lookup_en = 1;
         ld_addr  = 32'h1FC + 32'($urandom_range(0, 39));
         c.chk_ld = 1;
         foreach (mq[i]) begin
            if (mq[i].a[31:2] == ld_addr[31:2]) begin
               c.hit  = (mq[i].sz == 2) && (mq[i].a == ld_addr);
               c.conf = !c.hit;
               c.fd   = c.hit ? mq[i].d : 32'h0;
            end
         end
      end
      if (pending) begin
         if ($urandom_range(0, 99) < done_pct) mem_done = 1;
      end else begin
         if (proc2mem_command == 2'b10 && $urandom_range(0, 99) < acc_pct) mem_accept = 1;
         if ($urandom_range(0, 9) == 0) mem_done = 1;   // stray done, must be ignored
      end
      cyc_q.push_back(c);
      if (c.sc) begin
         mq.push_back(e);
         drain_q.push_back(fmt(e));
      end
      if (pending && mem_done) begin
         void'(mq.pop_front());
         pending = 0;
      end else if (mem_accept) begin
         pending = 1;
      end
   endtask

   task automatic do_reset(input bit late_done);
      @(posedge clock); #1;
      reset = 1; retireen = 0; storeing = 0; mem_accept = 0; mem_done = 0; ld_lookup_en = 0;
      @(posedge clock); #1;
      chk("rst_cmd", 64'(proc2mem_command), 64'd0);
      chk("rst_empty", 64'(wb_empty), 64'd1);
      reset = 0;
      mq.delete(); drain_q.delete(); cyc_q.delete();
      pending  = 0;
      mem_done = late_done;
      @(negedge clock);
      chk("rst_count", 64'(wb_count), 64'd0);
      chk("rst_storecomplete", 64'(storecomplete), 64'd0);
      chk("rst_fwd", {62'd0, wb_fwd_hit, wb_fwd_conflict}, 64'd0);
      chk("rst_bus", {proc2mem_addr, 24'd0, proc2mem_bmask}, 64'd0);
      chk("rst_bus_data", proc2mem_data, 64'd0);
   endtask

   always @(negedge clock) begin
      if (!reset && cyc_q.size() > 0) begin
         mc = cyc_q.pop_front();
         if (mc.chk_sc) chk("storecomplete", 64'(storecomplete), 64'(mc.sc));
         chk("wb_count", 64'(wb_count), 64'(mc.cnt));
         chk("wb_empty", 64'(wb_empty), 64'(mc.cnt == 0));
         if (mc.cnt == 0 || mc.pend) chk("cmd_none", 64'(proc2mem_command), 64'd0);
         if (mc.chk_ld) begin
            chk("fwd_hit", 64'(wb_fwd_hit), 64'(mc.hit));
            chk("fwd_conflict", 64'(wb_fwd_conflict), 64'(mc.conf));
            chk("fwd_data", 64'(wb_fwd_data), 64'(mc.fd));
         end
      end
      if (!reset && proc2mem_command == 2'b10) begin
         if (drain_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got store addr=%0h, required no request", proc2mem_addr);
         end else begin
            chk("bus_addr", 64'(proc2mem_addr), 64'(drain_q[0].addr));
            chk("bus_data", proc2mem_data, drain_q[0].data);
            chk("bus_bmask", 64'(proc2mem_bmask), 64'(drain_q[0].mask));
            if (mem_accept) begin
               $display("write addr=%08h data=%016h bmask=%02h", proc2mem_addr, proc2mem_data, proc2mem_bmask);
               void'(drain_q.pop_front());
            end
         end
      end
   end

   initial begin
      do_reset(0);
      // Fill with memory stalled: 5th store refused, then a pop alongside a store is still refused.
      repeat (5) step(1, 0, 0, 0);
      repeat (3) step(0, 100, 0, 0);
      step(1, 0, 100, 1);
      step(1, 0, 0, 1);
      repeat (2) step(0, 100, 0, 0);
      // Reset in the middle of a drain, followed by a stray done.
      do_reset(1);
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset(1);
         step(bit'($urandom_range(0, 1)), 60, 50, bit'($urandom_range(0, 1)));
      end
      repeat (60) step(0, 100, 100, 0);
      @(negedge clock);
      chk("drain_left", 64'(drain_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
